instr_fetch: RTL and testbench

Instruction fetch stage: owns the program counter, drives the read address of the combinational instruction memory, and registers each fetched word with its PC into an IF/ID pipeline register presented to decode over a valid/ready handshake. It sits directly upstream of the instruction memory (address side) and directly upstream of decode (data side). It accepts control-transfer redirects from execute and a halt request from the core controller.

---
 rtl/instr_fetch_if.sv | 32 +++
 rtl/instr_fetch.sv | 126 ++++++++++++
 tb/tb_instr_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// IF/ID handshake bundle between the fetch stage and decode.
//   id_valid      fetch -> decode  IF/ID register holds a valid instruction
//   id_ready      decode -> fetch  decode accepts the instruction this cycle
//   id_instr      fetch -> decode  fetched instruction word
//   id_pc         fetch -> decode  byte address of id_instr
//   id_misaligned fetch -> decode  the redirect that started this fetch run was misaligned
interface instr_fetch_if #(
    parameter int unsigned INS_ADDRESS = 9,
    parameter int unsigned INS_W       = 32
);
    logic                   id_valid;
    logic                   id_ready;
    logic [INS_W-1:0]       id_instr;
    logic [INS_ADDRESS-1:0] id_pc;
    logic                   id_misaligned;

    modport master (
        output id_valid,
        output id_instr,
        output id_pc,
        output id_misaligned,
        input  id_ready
    );

    modport slave (
        input  id_valid,
        input  id_instr,
        input  id_pc,
        input  id_misaligned,
        output id_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Owns the PC, addresses the combinational instruction
// memory and registers each fetched word with its PC into the IF/ID register.
//   clk, rst        clock, asynchronous active-high reset
//   imem_ra/imem_rd instruction memory read address (= pc) / combinational read data
//   redirect_valid  load redirect_pc (word-aligned) this cycle and flush IF/ID
//   redirect_pc     redirect target; nonzero low bits mark the following fetches misaligned
//   halt_req        suppress new fetches while high (a held instruction still drains)
//   id              IF/ID valid/ready handshake (master side)
//   fetch_count     number of completed IF/ID handshakes, wrapping
module instr_fetch #(
    parameter int unsigned           INS_ADDRESS = 9,
    parameter int unsigned           INS_W       = 32,
    parameter logic [INS_ADDRESS-1:0] RESET_PC   = '0,
    parameter int unsigned           CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [INS_ADDRESS-1:0] imem_ra,
    input  logic [INS_W-1:0]       imem_rd,
    input  logic                   redirect_valid,
    input  logic [INS_ADDRESS-1:0] redirect_pc,
    input  logic                   halt_req,
    instr_fetch_if.master          id,
    output logic [CNT_W-1:0]       fetch_count
);

    typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

    state_e state_q, state_d;
    logic   run_en;

    logic [INS_ADDRESS-1:0] pc_q, pc_d;
    logic                   valid_q, valid_d;
    logic [INS_W-1:0]       instr_q, instr_d;
    logic [INS_ADDRESS-1:0] id_pc_q, id_pc_d;
    logic                   mis_q, mis_d;
    logic                   flag_q, flag_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic slot_free;
    logic fetch;
    logic handshake;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:   state_d = StRun;
            StRun:    if (halt_req) state_d = StHalted;
            StHalted: if (!halt_req) state_d = StRun;
            default:  state_d = StBoot;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run_en = (state_q == StRun);
    end

    assign slot_free = !valid_q || id.id_ready;
    // Halt is checked combinationally so the cycle that raises it never fetches.
    assign fetch     = run_en && !halt_req && !redirect_valid && slot_free;
    assign handshake = valid_q && id.id_ready;

    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        id_pc_d = id_pc_q;
        mis_d   = mis_q;
        flag_d  = flag_q;
        // Counts the handshake even when a redirect flushes in the same cycle.
        cnt_d   = handshake ? cnt_q + CNT_W'(1) : cnt_q;

        if (redirect_valid) begin
            pc_d    = {redirect_pc[INS_ADDRESS-1:2], 2'b00};
            valid_d = 1'b0;
            flag_d  = |redirect_pc[1:0];
        end else if (fetch) begin
            instr_d = imem_rd;
            id_pc_d = pc_q;
            mis_d   = flag_q;
            valid_d = 1'b1;
            pc_d    = pc_q + INS_ADDRESS'(4);
        end else if (id.id_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            id_pc_q <= '0;
            mis_q   <= 1'b0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            id_pc_q <= id_pc_d;
            mis_q   <= mis_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_ra          = pc_q;
    assign id.id_valid      = valid_q;
    assign id.id_instr      = instr_q;
    assign id.id_pc         = id_pc_q;
    assign id.id_misaligned = mis_q;
    assign fetch_count      = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [8:0]  imem_ra;
    logic [31:0] imem_rd;
    logic        redirect_valid = 1'b0;
    logic [8:0]  redirect_pc = '0;
    logic        halt_req = 1'b0;
    logic [15:0] fetch_count;

    logic [31:0] mem [128];

    instr_fetch_if #(.INS_ADDRESS(9), .INS_W(32)) id_bus ();

    instr_fetch #(
        .INS_ADDRESS(9),
        .INS_W(32),
        .RESET_PC(9'd0),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_ra(imem_ra),
        .imem_rd(imem_rd),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt_req(halt_req),
        .id(id_bus),
        .fetch_count(fetch_count)
    );

    assign imem_rd = mem[imem_ra[8:2]];

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what decode should see, derived from the fetch rules.
    bit          m_booted;
    bit          m_halted;
    int          m_pc;
    bit          m_flag;
    bit          m_valid;
    logic [31:0] m_instr;
    int          m_id_pc;
    bit          m_mis;
    int          m_cnt;

    always @(posedge clk or posedge rst) begin : model
        bit f;
        if (rst) begin
            m_booted <= 1'b0;
            m_halted <= 1'b0;
            m_pc     <= 0;
            m_flag   <= 1'b0;
            m_valid  <= 1'b0;
            m_instr  <= '0;
            m_id_pc  <= 0;
            m_mis    <= 1'b0;
            m_cnt    <= 0;
        end else begin
            f = m_booted && !m_halted && !halt_req && !redirect_valid
                && (!m_valid || id_bus.id_ready);
            if (m_valid && id_bus.id_ready) m_cnt <= (m_cnt + 1) % 65536;
            if (redirect_valid) begin
                m_pc    <= (int'(redirect_pc) / 4) * 4;
                m_valid <= 1'b0;
                m_flag  <= (redirect_pc % 4) != 0;
            end else if (f) begin
                m_instr <= mem[m_pc / 4];
                m_id_pc <= m_pc;
                m_mis   <= m_flag;
                m_valid <= 1'b1;
                m_pc    <= (m_pc + 4) % 512;
            end else if (id_bus.id_ready) begin
                m_valid <= 1'b0;
            end
            // After the boot cycle the halted condition simply follows halt_req one cycle late.
            m_halted <= m_booted ? halt_req : 1'b0;
            m_booted <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("imem_ra", 64'(imem_ra), 64'(m_pc));
            chk("id_valid", 64'(id_bus.id_valid), 64'(m_valid));
            chk("fetch_count", 64'(fetch_count), 64'(m_cnt));
            if (m_valid) begin
                chk("id_instr", 64'(id_bus.id_instr), 64'(m_instr));
                chk("id_pc", 64'(id_bus.id_pc), 64'(m_id_pc));
                chk("id_misaligned", 64'(id_bus.id_misaligned), 64'(m_mis));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[0] = 32'h00007033;
        mem[1] = 32'h00100093;
        mem[2] = 32'h00200113;
        mem[3] = 32'h00208433;
        id_bus.id_ready = 1'b1;

        #1 rst = 1'b1;
        cyc();
        cyc();
        chk("rst_valid", 64'(id_bus.id_valid), 64'd0);
        chk("rst_ra", 64'(imem_ra), 64'd0);
        chk("rst_cnt", 64'(fetch_count), 64'd0);
        chk("rst_instr", 64'(id_bus.id_instr), 64'd0);
        chk("rst_mis", 64'(id_bus.id_misaligned), 64'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Stream with a back-pressure window while id_pc=4.
        cyc();
        chk("boot_valid", 64'(id_bus.id_valid), 64'd0);
        cyc();
        chk("first_valid", 64'(id_bus.id_valid), 64'd1);
        chk("first_pc", 64'(id_bus.id_pc), 64'h0);
        chk("first_instr", 64'(id_bus.id_instr), 64'h00007033);
        cyc();
        chk("s1_pc", 64'(id_bus.id_pc), 64'h4);
        id_bus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_instr", 64'(id_bus.id_instr), 64'h00100093);
            chk("bp_ra", 64'(imem_ra), 64'h8);
        end
        id_bus.id_ready = 1'b1;
        cyc();
        chk("rel_pc", 64'(id_bus.id_pc), 64'h8);
        chk("rel_instr", 64'(id_bus.id_instr), 64'h00200113);
        cyc();
        chk("s3_pc", 64'(id_bus.id_pc), 64'hC);
        chk("s3_instr", 64'(id_bus.id_instr), 64'h00208433);
        cyc();
        chk("cnt4", 64'(fetch_count), 64'd4);

        // Redirect concurrent with a handshake.
        redirect_valid = 1'b1;
        redirect_pc = 9'h010;
        cyc();
        redirect_valid = 1'b0;
        chk("rd_flush", 64'(id_bus.id_valid), 64'd0);
        chk("rd_cnt", 64'(fetch_count), 64'd5);
        cyc();
        chk("rd_pc", 64'(id_bus.id_pc), 64'h10);
        chk("rd_valid", 64'(id_bus.id_valid), 64'd1);

        // Misaligned redirect.
        redirect_valid = 1'b1;
        redirect_pc = 9'h00D;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        chk("mis_pc", 64'(id_bus.id_pc), 64'hC);
        chk("mis_flag", 64'(id_bus.id_misaligned), 64'd1);

        // Wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc = 9'h1FC;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        chk("wrap_pc0", 64'(id_bus.id_pc), 64'h1FC);
        chk("wrap_mis", 64'(id_bus.id_misaligned), 64'd0);
        cyc();
        chk("wrap_pc1", 64'(id_bus.id_pc), 64'h000);

        // Halt: held instruction drains, no new fetch, pc frozen.
        halt_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("halt_valid", 64'(id_bus.id_valid), 64'd0);
            chk("halt_ra", 64'(imem_ra), 64'h4);
        end
        halt_req = 1'b0;
        cyc();
        chk("resume_gap", 64'(id_bus.id_valid), 64'd0);
        cyc();
        chk("resume_valid", 64'(id_bus.id_valid), 64'd1);
        chk("resume_pc", 64'(id_bus.id_pc), 64'h4);

        // Asynchronous reset between edges.
        cyc();
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(id_bus.id_valid), 64'd0);
        chk("arst_cnt", 64'(fetch_count), 64'd0);
        chk("arst_ra", 64'(imem_ra), 64'd0);
        cyc();
        rst = 1'b0;

        // Randomized traffic, with occasional mid-run resets.
        for (int n = 0; n < 4000; n++) begin
            redirect_valid = ($urandom_range(0, 99) < 8);
            redirect_pc = 9'($urandom);
            halt_req = ($urandom_range(0, 99) < 12);
            id_bus.id_ready = ($urandom_range(0, 99) < 70);
            if (n % 997 == 500) begin
                #2 rst = 1'b1;
                cyc();
                rst = 1'b0;
            end else begin
                cyc();
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
